pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_skid_buf.sv | 55 +++++
 rtl/pipe_stage_reg.sv | 122 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared widths and control-bit layout for the pipeline stage register.
//   Payload layout (LSB first is not mandated here; widths only):
//     ALU result (WORD_W) + Rs data (WORD_W) + Rd data (WORD_W)
//     + Rd address (PIPE_REG_ADDR_W) + CCR (PIPE_CCR_W) = 54 bits.
//   Control bits: memRead, memWrite, regWrite at the indices below.
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int PIPE_WORD_W     = 16;
   localparam int PIPE_REG_ADDR_W = 3;
   localparam int PIPE_CCR_W      = 3;

   localparam int PIPE_DATA_W = 3 * PIPE_WORD_W + PIPE_REG_ADDR_W + PIPE_CCR_W;
   localparam int PIPE_CTRL_W = 3;

   localparam int CTRL_MEMREAD  = 0;
   localparam int CTRL_MEMWRITE = 1;
   localparam int CTRL_REGWRITE = 2;

   // True when the entry changes architectural state (memory or register file).
   function automatic logic ctrl_has_side_effect(input logic [PIPE_CTRL_W-1:0] c);
      return c[CTRL_MEMWRITE] | c[CTRL_REGWRITE];
   endfunction

   // True when the entry reads memory.
   function automatic logic ctrl_reads_mem(input logic [PIPE_CTRL_W-1:0] c);
      return c[CTRL_MEMREAD];
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// One-entry skid register holding an entry that arrived while the main
// register was full and stalled.
//   clk, rst   : clock, synchronous active-high reset
//   i_flush    : drop the held entry
//   i_load     : capture i_data / i_ctrl
//   i_unload   : entry moves on to the main register this cycle
//   o_valid    : skid holds an entry (registered)
//   o_data     : held payload
//   o_ctrl     : held control bits
// -----------------------------------------------------------------------------
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int CTRL_W = PIPE_CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CTRL_W-1:0] i_ctrl,
   input  logic              i_unload,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic [CTRL_W-1:0] o_ctrl
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [CTRL_W-1:0] r_ctrl;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_ctrl  <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_ctrl  <= i_ctrl;
      end else if (i_unload) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Valid/ready pipeline stage register with bubble-zeroed control bits.
//
// Handshake: an entry moves across a port on a posedge where valid and ready
// are both 1. in_valid/in_data/in_ctrl are only consumed when in_ready=1;
// out_valid, once high, stays high with stable out_data/out_ctrl until
// out_ready=1 retires it. flush and rst drop every held entry.
//
// Build option: define PIPE_STAGE_SKID_EN to add a one-entry skid register.
//   Undefined: in_ready = !out_valid || out_ready (combinational).
//   Defined  : in_ready is the registered "skid empty" flag, cutting the
//              out_ready -> in_ready path.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : upstream handshake
//   in_data, in_ctrl     : upstream payload and control bits
//   flush                : discard held and incoming entries
//   out_valid/out_ready  : downstream handshake
//   out_data, out_ctrl   : registered payload / control (ctrl=0 on bubbles)
// -----------------------------------------------------------------------------
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int CTRL_W = PIPE_CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
);

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [CTRL_W-1:0] r_out_ctrl;

   logic              w_accept;
   logic              w_retire;
   logic              w_main_free;
   logic              w_load;
   logic [DATA_W-1:0] w_load_data;
   logic [CTRL_W-1:0] w_load_ctrl;

   assign w_retire    = r_out_valid && out_ready;
   // Main register can take a new entry: empty, or its entry leaves this edge.
   assign w_main_free = !r_out_valid || out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic              w_skid_valid;
   logic [DATA_W-1:0] w_skid_data;
   logic [CTRL_W-1:0] w_skid_ctrl;
   logic              w_skid_load;
   logic              w_skid_unload;

   // Registered: skid flag comes straight from a flop.
   assign in_ready      = !w_skid_valid;
   assign w_accept      = in_valid && in_ready;
   assign w_skid_load   = w_accept && !w_main_free;
   assign w_skid_unload = w_skid_valid && w_retire;

   // While skid is full in_ready=0, so the only main load is the skid entry.
   assign w_load      = w_skid_unload || (w_accept && w_main_free);
   assign w_load_data = w_skid_valid ? w_skid_data : in_data;
   assign w_load_ctrl = w_skid_valid ? w_skid_ctrl : in_ctrl;

   pipe_skid_buf #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .i_flush  (flush),
      .i_load   (w_skid_load),
      .i_data   (in_data),
      .i_ctrl   (in_ctrl),
      .i_unload (w_skid_unload),
      .o_valid  (w_skid_valid),
      .o_data   (w_skid_data),
      .o_ctrl   (w_skid_ctrl)
   );
`else
   assign in_ready    = w_main_free;
   assign w_accept    = in_valid && in_ready;
   assign w_load      = w_accept;
   assign w_load_data = in_data;
   assign w_load_ctrl = in_ctrl;
`endif

   // Priority: rst > flush > load > retire. out_data is left alone on
   // flush/retire; only out_ctrl is zeroed so bubbles carry no side effects.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ctrl  <= '0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
         r_out_ctrl  <= '0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_load_data;
         r_out_ctrl  <= w_load_ctrl;
      end else if (w_retire) begin
         r_out_valid <= 1'b0;
         r_out_ctrl  <= '0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ctrl  = r_out_ctrl;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Bench for pipe_stage_reg; follows PIPE_STAGE_SKID_EN if defined at build.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

   localparam int DW = 54;
   localparam int CW = 3;
   localparam int W  = DW + CW;

`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;

   always #5 clk = ~clk;

   pipe_stage_reg dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   // Entries currently held by the stage, oldest first: {ctrl, data}.
   logic [W-1:0] exp_q[$];
   bit           m_init = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- table vectors ----------------
   typedef struct {
      logic          r;
      logic          iv;
      logic [DW-1:0] d;
      logic [CW-1:0] c;
      logic          fl;
      logic          ordy;
      logic          e_rdy;
      logic          e_val;
      logic [DW-1:0] e_d;
      logic [CW-1:0] e_c;
   } vec_t;

   vec_t tbl[12];

   function automatic vec_t mk(input int r, input int iv, input longint d, input int c,
                               input int fl, input int ordy, input int er, input int ev,
                               input longint ed, input int ec);
      vec_t v;
      v.r     = r[0];
      v.iv    = iv[0];
      v.d     = d[DW-1:0];
      v.c     = c[CW-1:0];
      v.fl    = fl[0];
      v.ordy  = ordy[0];
      v.e_rdy = er[0];
      v.e_val = ev[0];
      v.e_d   = ed[DW-1:0];
      v.e_c   = ec[CW-1:0];
      return v;
   endfunction

   // ---------------- driver with reference model ----------------
   // Model: the stage is a FIFO of capacity 1 (plain) or 2 (skid); the head
   // is what is shown downstream.
   task automatic cycle(input logic r, input logic iv, input logic [DW-1:0] d,
                        input logic [CW-1:0] c, input logic fl, input logic ordy);
      logic m_rdy;
      logic m_acc;
      logic m_ret;
      @(negedge clk);
      rst       = r;
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      flush     = fl;
      out_ready = ordy;
      #1;
      if (SKID) m_rdy = (exp_q.size() < 2);
      else      m_rdy = (exp_q.size() == 0) || ordy;
      if (m_init) begin
         chk("in_ready", 64'(in_ready), 64'(m_rdy));
         chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
         if (exp_q.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(exp_q[0][DW-1:0]));
            chk("out_ctrl", 64'(out_ctrl), 64'(exp_q[0][W-1:DW]));
         end else begin
            chk("bubble_ctrl", 64'(out_ctrl), 64'(0));
         end
      end
      m_ret = (exp_q.size() > 0) && ordy;
      m_acc = iv && m_rdy;
      @(posedge clk);
      if (r) begin
         exp_q.delete();
         m_init = 1'b1;
      end else if (fl) begin
         exp_q.delete();
      end else begin
         if (m_ret) void'(exp_q.pop_front());
         if (m_acc) exp_q.push_back({c, d});
      end
   endtask

   // ---------------- test ----------------
   initial begin
      logic [63:0] rnd;

      // Reset with traffic, streaming, bubble, hold, flush of incoming entry.
      tbl[0]  = mk(1, 1, 'h3FF, 7, 0, 1, 1, 0, 0,     0);
      tbl[1]  = mk(1, 1, 'h3FF, 7, 0, 1, 1, 0, 0,     0);
      tbl[2]  = mk(0, 1, 1,     4, 0, 1, 1, 1, 1,     4);
      tbl[3]  = mk(0, 1, 2,     4, 0, 1, 1, 1, 2,     4);
      tbl[4]  = mk(0, 1, 3,     4, 0, 1, 1, 1, 3,     4);
      tbl[5]  = mk(0, 1, 4,     4, 0, 1, 1, 1, 4,     4);
      tbl[6]  = mk(0, 0, 0,     0, 0, 1, 1, 0, 4,     0);
      tbl[7]  = mk(0, 1, 'hA,   1, 0, 0, int'(SKID), 1, 'hA, 1);
      tbl[8]  = mk(0, 0, 0,     0, 0, 0, int'(SKID), 1, 'hA, 1);
      tbl[9]  = mk(0, 0, 0,     0, 0, 1, 1, 0, 'hA,  0);
      tbl[10] = mk(0, 1, 'hB,   2, 1, 1, 1, 0, 'hA,  0);
      tbl[11] = mk(0, 1, 'hC,   4, 0, 1, 1, 1, 'hC,  4);

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         rst       = tbl[i].r;
         in_valid  = tbl[i].iv;
         in_data   = tbl[i].d;
         in_ctrl   = tbl[i].c;
         flush     = tbl[i].fl;
         out_ready = tbl[i].ordy;
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_in_ready", i),  64'(in_ready),  64'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_val));
         chk($sformatf("tbl%0d_out_data", i),  64'(out_data),  64'(tbl[i].e_d));
         chk($sformatf("tbl%0d_out_ctrl", i),  64'(out_ctrl),  64'(tbl[i].e_c));
      end

      // Model-tracked phase starts from a fresh reset.
      cycle(1, 0, '0, '0, 0, 0);
      cycle(1, 0, '0, '0, 0, 0);

      // Stall: main holds 0x5 for three cycles; 0x6 then queues (skid) or waits.
      cycle(0, 1, 54'h5, 3'b001, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, '0, '0, 0, 0);
         #1;
         chk("stall_hold_data", 64'(out_data), 64'h5);
      end
      cycle(0, 1, 54'h6, 3'b001, 0, 0);
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_still_5", 64'(out_data), 64'h5);
      cycle(0, !SKID, 54'h6, 3'b001, 0, 1);
      #1;
      chk("stall_second_valid", 64'(out_valid), 64'(1));
      chk("stall_second_data", 64'(out_data), 64'h6);
      chk("stall_ready_back", 64'(in_ready), 64'(1));
      cycle(0, 0, '0, '0, 0, 1);
      #1;
      chk("stall_drained", 64'(out_valid), 64'(0));

      // Flush with main=0x7, skid=0x8 (skid build), incoming 0x9.
      cycle(0, 1, 54'h7, 3'b010, 0, 0);
      cycle(0, 1, 54'h8, 3'b001, 0, 0);
      cycle(0, 1, 54'h9, 3'b100, 1, 1);
      #1;
      chk("flush_valid", 64'(out_valid), 64'(0));
      chk("flush_ctrl", 64'(out_ctrl), 64'(0));
      for (int i = 0; i < 2; i++) begin
         cycle(0, 0, '0, '0, 0, 1);
         #1;
         chk("flush_stays_empty", 64'(out_valid), 64'(0));
      end

      // Back-to-back: accept and retire on every edge, no bubble.
      cycle(0, 1, 54'h100, 3'b100, 0, 1);
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1, DW'(64'h101 + 64'(i)), 3'b100, 0, 1);
         #1;
         chk("b2b_valid", 64'(out_valid), 64'(1));
         chk("b2b_data", 64'(out_data), 64'h101 + 64'(i));
      end
      cycle(0, 0, '0, '0, 0, 1);

      // Random traffic against the model.
      for (int i = 0; i < 10000; i++) begin
         rnd = {$urandom, $urandom};
         cycle($urandom_range(0, 199) == 0,
               $urandom_range(0, 9) < 7,
               rnd[DW-1:0],
               CW'($urandom_range(0, 7)),
               $urandom_range(0, 49) == 0,
               $urandom_range(0, 9) < 6);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
